pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Output stage directly downstream of the SPI register bank. It consumes the five configuration bytes (output enables, PWM enables, duty cycle) and drives 16 chip outputs. Each output is forced low, held high, or driven by one shared 8-bit PWM waveform. The duty cycle is double-buffered and applied only at a period boundary, so no output ever sees a truncated or glitched pulse.

## Interface
Parameters:
- CLK_DIV, default 3000: `clk` cycles per PWM count step; legal range 1..65535. PWM period is 256*CLK_DIV cycles.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- en_reg_out_7_0  input  8  output enables for bits 7:0 (1 = enabled).
- en_reg_out_15_8  input  8  output enables for bits 15:8.
- en_reg_pwm_7_0  input  8  PWM select for bits 7:0 (1 = PWM, 0 = static high).
- en_reg_pwm_15_8  input  8  PWM select for bits 15:8.
- pwm_duty_cycle  input  8  requested duty; high time = duty/256 of the period, except 0xFF.
- out_7_0  output  8  registered chip outputs, bits 7:0.
- out_15_8  output  8  registered chip outputs, bits 15:8.
- period_start  output  1  one-cycle pulse in the cycle the active duty is (re)loaded.

## Operation
- Prescaler `pre_cnt` counts 0..CLK_DIV-1 and wraps. `tick` is 1 when pre_cnt == CLK_DIV-1. With CLK_DIV = 1, tick is constant 1.
- PWM counter `pwm_cnt` (8 bits) increments on tick and wraps 255 -> 0 naturally.
- Period start is the cycle where pre_cnt == 0 and pwm_cnt == 0. In that cycle `duty_act` <= pwm_duty_cycle and period_start = 1. The first cycle after reset release is therefore always a period start.
- Waveform `pwm_raw` is computed against the current duty_act:
  - duty_act == 0xFF: pwm_raw = 1 for the whole period (full on).
  - otherwise: pwm_raw = (pwm_cnt < duty_act).
  - duty_act == 0: pwm_raw = 0 for the whole period.
- Per bit i (0..15), with en_out/en_pwm as the concatenated 16-bit enables: next out[i] = en_out[i] ? (en_pwm[i] ? pwm_raw : 1) : 0.
- Enable inputs take effect on the next clock; they are not buffered to the period boundary.
- Duty writes arriving mid-period are ignored until the next period start. When several writes land in one period, the last value present at the period start wins.

## Timing
- Reset (rst_n low at a clock edge): pre_cnt = 0, pwm_cnt = 0, duty_act = 0, out_7_0 = 0x00, out_15_8 = 0x00, period_start = 0. Reset mid-period abandons the period immediately, with no completion of the current pulse.
- Output latency: out[i] reflects enables and pwm_raw with 1 cycle of latency (registered). period_start is combinational from the counter state.
- Reload: duty_act updates at the edge ending the period-start cycle. The first PWM-driven output using the new duty appears 1 cycle after period_start.
- For duty_act = D with 0 < D < 0xFF: high time is D*CLK_DIV cycles, low time is (256-D)*CLK_DIV cycles, and each period has exactly one rising and one falling edge.
- No handshake with the SPI stage. The inputs are already in the clk domain and are sampled every cycle.

## Structure
- Shared package: PWM_CNT_W = 8, DUTY_FULL = 8'hFF, CLK_DIV_DEFAULT = 3000, and the prescaler width function (clog2 of CLK_DIV, minimum 1).
- Sub-module `pwm_prescaler` (parameter CLK_DIV; ports clk, rst_n, tick, at_zero). It owns pre_cnt. The top level holds pwm_cnt, duty_act, the compare, and the 16-bit output mux/register.

## Test plan
Bench uses CLK_DIV = 4 (period = 1024 cycles).
- Reset with all enables 0xFF, pwm 0x0000, duty 0x80, then release -> all 16 outputs high 1 cycle after release; period_start pulses on the first cycle and every 1024 cycles after.
- en_out = 0x00FF, en_pwm = 0x0001, duty = 0x80 -> bit 0 high 512 cycles / low 512 cycles; bits 7:1 static high; bits 15:8 low.
- Duty sweep 0x00, 0x01, 0xFE, 0xFF on a PWM-enabled bit -> high times of 0, 4, 1016, 1024 cycles per period (0xFF has no low phase).
- Write duty 0x40 at cycle 300 of a period running 0x80 -> current period keeps 512 high cycles; next period has 256 high cycles; change occurs only after period_start.
- Clear en_out[3] while bit 3 is high mid-pulse -> out[3] low 1 cycle later; set it again -> it resumes in phase with the running counter.
- Assert rst_n low at pwm_cnt = 0x37 -> outputs 0x0000 the next cycle, counters 0; after release a fresh period starts with period_start = 1 and duty reloaded.

Source files
------------

// File: rtl/pwm_peripheral_pkg.sv
// Shared PWM constants and the prescaler counter width helper.
// Pure declarations: no logic, no latency, no flow control.
package pwm_peripheral_pkg;

  localparam int                   PWM_CNT_W       = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL       = 8'hFF;
  localparam int                   CLK_DIV_DEFAULT = 3000;

  // A divider of 1 still needs a 1-bit counter to keep the port widths legal.
  function automatic int pre_cnt_w(input int clk_div);
    return (clk_div <= 2) ? 1 : $clog2(clk_div);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running 0..CLK_DIV-1 prescaler; tick flags the last count, at_zero the first.
// Both flags are combinational from the count register; no backpressure.
module pwm_prescaler
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic at_zero
);

  localparam int           W    = pre_cnt_w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_pre_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else if (r_pre_cnt == LAST) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + W'(1);
    end
  end

  // With CLK_DIV == 1 the count never leaves zero, so tick and at_zero are both constant 1.
  assign tick    = (r_pre_cnt == LAST);
  assign at_zero = (r_pre_cnt == '0);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-bit output stage: each bit low, static high or shared PWM; duty reloads only at period start.
// Outputs registered (1 cycle), period_start combinational; inputs sampled every cycle, no backpressure.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  logic                 w_tick;
  logic                 w_at_zero;
  logic                 w_period_start;
  logic                 w_pwm_raw;
  logic [PWM_CNT_W-1:0] w_duty_eff;
  logic [15:0]          w_en_out;
  logic [15:0]          w_en_pwm;
  logic [15:0]          w_out_nxt;

  logic [PWM_CNT_W-1:0] r_pwm_cnt;
  logic [PWM_CNT_W-1:0] r_duty_act;
  logic [15:0]          r_out;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (w_tick),
    .at_zero (w_at_zero)
  );

  assign w_period_start = w_at_zero && (r_pwm_cnt == '0);
  assign period_start   = rst_n && w_period_start;

  // The first cycle of a period compares against the duty being loaded, so every
  // cycle of a period, including its first, uses one and the same duty value.
  assign w_duty_eff = w_period_start ? pwm_duty_cycle : r_duty_act;
  assign w_pwm_raw  = (w_duty_eff == DUTY_FULL) || (r_pwm_cnt < w_duty_eff);

  assign w_en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign w_out_nxt = w_en_out & (~w_en_pwm | {16{w_pwm_raw}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt  <= '0;
      r_duty_act <= '0;
      r_out      <= '0;
    end else begin
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_CNT_W'(1);
      end
      if (w_period_start) begin
        r_duty_act <= pwm_duty_cycle;
      end
      r_out <= w_out_nxt;
    end
  end

  assign out_7_0  = r_out[7:0];
  assign out_15_8 = r_out[15:8];

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomised and directed bench for pwm_peripheral against a position-in-period reference model.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [7:0]  out_7_0;
  logic [7:0]  out_15_8;
  logic        period_start;
  logic [15:0] out16;

  always #5 clk = ~clk;

  assign out16 = {out_15_8, out_7_0};

  pwm_peripheral #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out_7_0         (out_7_0),
    .out_15_8        (out_15_8),
    .period_start    (period_start)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: position within the period in clk cycles; duty latched at position 0.
  function automatic bit high_at(input int pos, input logic [7:0] d);
    if (d == 8'hFF) return 1'b1;
    return (pos / CLK_DIV) < int'(d);
  endfunction

  function automatic int exp_high(input logic [7:0] d);
    return (d == 8'hFF) ? PERIOD : int'(d) * CLK_DIV;
  endfunction

  int          m_pos   = 0;
  logic [7:0]  m_duty  = '0;
  logic [15:0] m_out   = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_n === 1'b0) begin
      m_valid = 1'b1;
      m_pos   = 0;
      m_out   = '0;
    end else if (m_valid) begin
      if (m_pos == 0) m_duty = duty;
      m_out = en_out & (~en_pwm | (high_at(m_pos, m_duty) ? 16'hFFFF : 16'h0000));
      m_pos = (m_pos + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("out", {16'h0, out16}, {16'h0, m_out});
      chk("period_start", {31'h0, period_start}, {31'h0, (rst_n && (m_pos == 0))});
    end
  end

  task automatic wait_ps();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < PERIOD + 8; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("period_start_seen", {31'h0, seen}, 32'h1);
  endtask

  // Call from the negedge of a period-start cycle; counts high cycles of bit b over one period.
  task automatic measure(input int b, input int wr_at, input logic [7:0] wr_val, output int hi);
    hi = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (out16[b]) hi++;
      if (i == wr_at) duty = wr_val;
    end
  endtask

  initial begin
    int          hi;
    int          n_ps;
    logic [7:0]  sweep [4];

    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h80;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release: immediate period start, all outputs high one cycle later.
    @(negedge clk);
    chk("first_period_start", {31'h0, period_start}, 32'h1);
    @(negedge clk);
    chk("all_high_after_release", {16'h0, out16}, 32'hFFFF);
    n_ps = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      if (period_start) n_ps++;
    end
    chk("period_start_count", n_ps, 3);

    // One PWM bit, seven static bits, upper byte disabled.
    en_out = 16'h00FF;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    wait_ps();
    measure(0, -1, 8'h00, hi);
    chk("duty80_high", hi, 512);
    chk("static_bits", {16'h0, out16 & 16'hFFFE}, 32'h00FE);

    // Duty boundary sweep.
    sweep[0] = 8'h00; sweep[1] = 8'h01; sweep[2] = 8'hFE; sweep[3] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      duty = sweep[k];
      wait_ps();
      measure(0, -1, 8'h00, hi);
      chk($sformatf("sweep_%02h_high", sweep[k]), hi, exp_high(sweep[k]));
    end

    // Mid-period duty write only applies from the next period.
    duty = 8'h80;
    wait_ps();
    wait_ps();
    measure(0, 300, 8'h40, hi);
    chk("midwrite_cur_period", hi, 512);
    measure(0, -1, 8'h00, hi);
    chk("midwrite_next_period", hi, 256);

    // Output enable toggled mid-pulse.
    en_out = 16'hFFFF;
    en_pwm = 16'h0008;
    duty   = 8'h80;
    wait_ps();
    repeat (100) @(negedge clk);
    chk("bit3_high_mid_pulse", {31'h0, out16[3]}, 32'h1);
    en_out[3] = 1'b0;
    @(negedge clk);
    chk("bit3_disabled", {31'h0, out16[3]}, 32'h0);
    repeat (50) @(negedge clk);
    en_out[3] = 1'b1;
    @(negedge clk);
    chk("bit3_reenabled", {31'h0, out16[3]}, 32'h1);

    // Reset while pwm_cnt == 0x37, new duty picked up at the fresh period.
    en_pwm = 16'hFFFF;
    wait_ps();
    repeat (8'h37 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    duty = 8'h20;
    @(negedge clk);
    chk("ps_low_in_reset", {31'h0, period_start}, 32'h0);
    @(negedge clk);
    chk("out_cleared_by_reset", {16'h0, out16}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ps_after_reset", {31'h0, period_start}, 32'h1);
    measure(0, -1, 8'h00, hi);
    chk("duty_reloaded_after_reset", hi, exp_high(8'h20));

    // Random enables, duty writes and occasional resets, checked cycle by cycle.
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 31) == 0) en_out = 16'($urandom);
      if ($urandom_range(0, 31) == 0) en_pwm = 16'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0:       duty = 8'h00;
          1:       duty = 8'hFF;
          default: duty = 8'($urandom);
        endcase
      end
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
